// File: rtl/psx_pad_poller.sv
// psx_pad_poller: PlayStation pad poll engine (ATT/CLK/CMD/DAT/ACK) producing button, ID and stick words.
// Define PSX_ANALOG_EN for 9-byte analog frames; otherwise 5-byte digital frames with analog tied to 0.
module psx_pad_poller #(
  parameter int CLK_DIV     = 200,
  parameter int POLL_PERIOD = 1666667,
  parameter int ATT_SETUP   = 2000,
  parameter int ACK_TIMEOUT = 1000
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        poll_en,
  output logic        busy,
  output logic [15:0] buttons,
  output logic [7:0]  pad_id,
  output logic [31:0] analog,
  output logic        frame_valid,
  output logic        change,
  output logic        err,
  output logic        psx_att,
  output logic        psx_clk,
  output logic        psx_cmd,
  input  logic        psx_dat,
  input  logic        psx_ack
);
`ifdef PSX_ANALOG_EN
  localparam int NB = 9;
`else
  localparam int NB = 5;
`endif
  localparam int FW = (NB - 1) * 8;
  localparam int RW = (NB - 2) * 8;
  localparam int M1 = (ATT_SETUP > 2 * CLK_DIV) ? ATT_SETUP : 2 * CLK_DIV;
  localparam int CMAX = (M1 > ACK_TIMEOUT) ? M1 : ACK_TIMEOUT;
  localparam int CW = $clog2(CMAX + 1);
  localparam int TW = $clog2(POLL_PERIOD + 1);
  localparam logic [2:0] IDLE = 3'd0, SETUP = 3'd1, SHIFT = 3'd2, ACK_WAIT = 3'd3, GAP = 3'd4, ABORT = 3'd5;
  logic [2:0] state;
  logic [1:0] dat_q, ack_q;
  logic dat_s, ack_s;
  logic [TW-1:0] timer;
  logic pend, expire, start;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [3:0] byte_idx;
  logic [7:0] sr, cur_cmd;
  logic [RW-1:0] rx;
  logic [FW-1:0] frame;
  logic [15:0] new_buttons;
  logic hdr_ok;
  assign dat_s = dat_q[1];
  assign ack_s = ack_q[1];
  assign busy = ~psx_att;
  assign expire = timer == TW'(POLL_PERIOD - 1);
  assign start = state == IDLE && poll_en && (expire || pend);
  assign cur_cmd = byte_idx == 4'd0 ? 8'h01 : byte_idx == 4'd1 ? 8'h42 : 8'h00;
  // frame holds reply bytes 1..NB-1, byte 1 in the low octet
  assign frame = {sr, rx};
  assign hdr_ok = frame[15:8] == 8'h5A;
  assign new_buttons = ~frame[31:16];
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      dat_q <= 2'b11;
      ack_q <= 2'b11;
      timer <= '0;
      pend  <= 1'b0;
    end else begin
      dat_q <= {dat_q[0], psx_dat};
      ack_q <= {ack_q[0], psx_ack};
      timer <= (start || expire) ? '0 : timer + TW'(1);
      pend  <= !start && (pend || expire) && !(state == IDLE && !poll_en);
    end
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      sr          <= '0;
      rx          <= '0;
      psx_att     <= 1'b1;
      psx_clk     <= 1'b1;
      psx_cmd     <= 1'b1;
      buttons     <= '0;
      pad_id      <= '0;
      analog      <= '0;
      frame_valid <= 1'b0;
      change      <= 1'b0;
      err         <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      change      <= 1'b0;
      err         <= 1'b0;
      cnt         <= cnt + CW'(1);
      case (state)
        IDLE: if (start) begin
          state    <= SETUP;
          psx_att  <= 1'b0;
          cnt      <= '0;
          byte_idx <= '0;
        end
        SETUP: if (cnt == CW'(ATT_SETUP - 1)) begin
          state   <= SHIFT;
          psx_clk <= 1'b0;
          psx_cmd <= cur_cmd[0];
          cnt     <= '0;
          bit_idx <= '0;
        end
        SHIFT: begin
          if (cnt == CW'(CLK_DIV - 1)) begin
            psx_clk <= 1'b1;
            sr      <= {dat_s, sr[7:1]};
          end
          if (cnt == CW'(2 * CLK_DIV - 1)) begin
            cnt <= '0;
            if (bit_idx != 3'd7) begin
              bit_idx <= bit_idx + 3'd1;
              psx_clk <= 1'b0;
              psx_cmd <= cur_cmd[bit_idx + 3'd1];
            end else begin
              rx      <= frame[FW-1:8];
              psx_cmd <= 1'b1;
              if (byte_idx == 4'(NB - 1)) begin
                state   <= IDLE;
                psx_att <= 1'b1;
                if (hdr_ok) begin
                  frame_valid <= 1'b1;
                  change      <= new_buttons != buttons;
                  buttons     <= new_buttons;
                  pad_id      <= frame[7:0];
`ifdef PSX_ANALOG_EN
                  analog      <= frame[63:32];
`endif
                end else err <= 1'b1;
              end else state <= ACK_WAIT;
            end
          end
        end
        ACK_WAIT: if (!ack_s) begin
          state <= GAP;
          cnt   <= '0;
        end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
          state <= ABORT;
          err   <= 1'b1;
        end
        GAP: if (cnt == CW'(CLK_DIV - 1)) begin
          // every command byte after the first starts with a 0 bit
          state    <= SHIFT;
          byte_idx <= byte_idx + 4'd1;
          bit_idx  <= '0;
          psx_clk  <= 1'b0;
          psx_cmd  <= 1'b0;
          cnt      <= '0;
        end
        ABORT: begin
          state   <= IDLE;
          psx_att <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
